// File: rtl/counter_sched_pkg.sv
// Package for counter_scheduler: scheduler state encoding, default widths and a
// constant-evaluable clog2 used to size the round-robin pointer.
// No ports.
package counter_sched_pkg;

  localparam int unsigned LIMIT_W_DEFAULT = 17;
  localparam int unsigned N_REQ_DEFAULT   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitRise,
    StRun,
    StDone
  } sched_state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at index ptr, wrapping to 0, and returns a one-hot grant
// (all zero when no request is present). With ptr tied to 0 it degenerates into a
// fixed-priority arbiter where the lowest index wins.
// Ports:
//   req  in   N_REQ   request vector
//   ptr  in   PTR_W   index at which the search starts
//   gnt  out  N_REQ   one-hot winner or zero
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    // First pass: indices at or above the pointer.
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
    // Second pass: wrap around to the indices below the pointer.
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req[j] && (j < int'(ptr))) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one counter between N_REQ requesters. Arbitrates among level requests,
// latches the winner's limit, pulses the counter start, tracks the count to
// completion and returns a per-requester done pulse plus a qualified result stream.
//
// Configuration macro: COUNTER_SCHED_FIXED_PRIO_EN
//   defined   -> fixed priority (lowest index wins), no round-robin pointer
//   undefined -> round-robin, pointer advances past the last owner
//
// Ports:
//   clk           in   1              clock, all logic on posedge
//   reset         in   1              synchronous, active-high
//   req           in   N_REQ          level request per requester
//   req_limit     in   N_REQ*LIMIT_W  limit per requester, slice i at [i*LIMIT_W +: LIMIT_W]
//   grant         out  N_REQ          one-hot owner, held for the whole job
//   done          out  N_REQ          one-cycle pulse to the owner at job end
//   busy          out  1              job in progress
//   res_valid     out  1              res_value holds a live count for the owner
//   res_value     out  LIMIT_W        registered copy of cnt_result
//   cnt_start     out  1              counter start strobe
//   cnt_limit     out  LIMIT_W        counter limit, stable for the whole job
//   cnt_counting  in   1              counter running flag
//   cnt_result    in   LIMIT_W        counter current value
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEFAULT,
  parameter int unsigned LIMIT_W = LIMIT_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*LIMIT_W-1:0] req_limit,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     res_valid,
  output logic [LIMIT_W-1:0]       res_value,
  output logic                     cnt_start,
  output logic [LIMIT_W-1:0]       cnt_limit,
  input  logic                     cnt_counting,
  input  logic [LIMIT_W-1:0]       cnt_result
);

  localparam int unsigned PtrW = (N_REQ > 1) ? clog2(N_REQ) : 1;

  sched_state_t        state_q;
  logic [N_REQ-1:0]    win_gnt;
  logic [LIMIT_W-1:0]  win_limit;
  logic [PtrW-1:0]     arb_ptr;

`ifdef COUNTER_SCHED_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_d;

  assign arb_ptr = ptr_q;

  // Next search starts just past the current owner.
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        ptr_d = (i == int'(N_REQ) - 1) ? '0 : PtrW'(i + 1);
      end
    end
  end
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PtrW)
  ) u_arbiter (
    .req (req),
    .ptr (arb_ptr),
    .gnt (win_gnt)
  );

  always_comb begin
    win_limit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_gnt[i]) begin
        win_limit = req_limit[i*LIMIT_W +: LIMIT_W];
      end
    end
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      grant     <= '0;
      done      <= '0;
      res_valid <= 1'b0;
      res_value <= '0;
      cnt_start <= 1'b0;
      cnt_limit <= '0;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
      ptr_q     <= '0;
`endif
    end else begin
      done      <= '0;
      cnt_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The counter has no reset; never restart it while a stale job still runs.
          if ((|req) && !cnt_counting) begin
            grant     <= win_gnt;
            cnt_limit <= win_limit;
            if (win_limit == '0) begin
              // A zero limit would make the counter wrap the full range.
              state_q <= StDone;
            end else begin
              cnt_start <= 1'b1;
              state_q   <= StStart;
            end
          end
        end
        StStart: begin
          state_q <= StWaitRise;
        end
        StWaitRise: begin
          if (cnt_counting) begin
            res_valid <= 1'b1;
            res_value <= cnt_result;
            state_q   <= StRun;
          end
        end
        StRun: begin
          if (cnt_counting) begin
            res_value <= cnt_result;
          end else begin
            res_valid <= 1'b0;
            state_q   <= StDone;
          end
        end
        StDone: begin
          done      <= grant;
          grant     <= '0;
          res_valid <= 1'b0;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
          ptr_q     <= ptr_d;
`endif
          state_q   <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler with a behavioural model of the shared counter.
// Expected done pulses (owner, latency) and result values are queued when a job
// is requested and popped by a negedge monitor as the DUT produces them.
module tb_counter_scheduler;

  localparam int NR = 4;
  localparam int LW = 17;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*LW-1:0]  req_limit = '0;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic              busy;
  logic              res_valid;
  logic [LW-1:0]     res_value;
  logic              cnt_start;
  logic [LW-1:0]     cnt_limit;
  logic              cnt_counting = 1'b0;
  logic [LW-1:0]     cnt_result = '0;
  logic [LW-1:0]     cnt_lim_q = '0;

  counter_scheduler #(
    .N_REQ   (NR),
    .LIMIT_W (LW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_limit    (req_limit),
    .grant        (grant),
    .done         (done),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_value    (res_value),
    .cnt_start    (cnt_start),
    .cnt_limit    (cnt_limit),
    .cnt_counting (cnt_counting),
    .cnt_result   (cnt_result)
  );

  always #5 clk = ~clk;

  // Counter model: no reset; counts 0..limit-1 starting the cycle after start.
  always @(posedge clk) begin
    if (cnt_start) begin
      cnt_counting <= 1'b1;
      cnt_result   <= '0;
      cnt_lim_q    <= cnt_limit;
    end else if (cnt_counting) begin
      if (cnt_result == cnt_lim_q - 17'd1) cnt_counting <= 1'b0;
      else cnt_result <= cnt_result + 17'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0] owner;
    int            lat;
  } done_exp_t;

  done_exp_t     done_q[$];
  logic [LW-1:0] res_q[$];

  int   n_err = 0;
  int   n_checks = 0;
  int   done_seen = 0;
  int   starts = 0;
  int   gcyc = 0;
  bit   res_en = 1'b1;
  logic [NR-1:0] prev_grant = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (!reset) begin
      check_eq("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      check_eq("done_in_prev_grant", 32'(done & ~prev_grant), 32'd0);
      if (done != '0) begin
        done_seen++;
        if (done_q.size() == 0) begin
          check_eq("done_unexpected", 32'(done), 32'd0);
        end else begin
          done_exp_t e;
          e = done_q.pop_front();
          check_eq("done_owner", 32'(done), 32'(e.owner));
          check_eq("done_latency", 32'(cyc - gcyc), 32'(e.lat));
        end
      end
      if (grant != '0 && prev_grant == '0) gcyc = cyc;
      if (res_en && res_valid) begin
        if (res_q.size() == 0) begin
          check_eq("res_unexpected", 32'(res_valid), 32'd0);
        end else begin
          check_eq("res_value", 32'(res_value), 32'(res_q.pop_front()));
        end
      end
      if (cnt_start) starts++;
    end
    prev_grant = grant;
  end

  task automatic push_job(input int idx, input int lim);
    done_exp_t e;
    e.owner = NR'(1) << idx;
    e.lat   = (lim == 0) ? 1 : lim + 3;
    done_q.push_back(e);
    for (int k = 0; k < lim; k++) res_q.push_back(LW'(k));
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_limit(input int idx, input int v);
    req_limit[idx*LW +: LW] = LW'(v);
  endtask

  task automatic apply_reset();
    tick();
    req   = '0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int budget);
    int n = 0;
    while (grant == '0 && n < budget) begin tick(); n++; end
    check_eq("grant_seen", 32'(grant != '0), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || done_q.size() != 0) && n < budget) begin tick(); n++; end
    tick();
    check_eq("jobs_drained", 32'(done_q.size()), 32'd0);
    check_eq("res_drained", 32'(res_q.size()), 32'd0);
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n = 0;
    while (done_seen < target && n < budget) begin tick(); n++; end
    check_eq("dones_seen", 32'(done_seen), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int viol;
    int n;

    // Reset state.
    repeat (3) tick();
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_res_valid", 32'(res_valid), 0);
    check_eq("rst_res_value", 32'(res_value), 0);
    check_eq("rst_cnt_start", 32'(cnt_start), 0);
    check_eq("rst_cnt_limit", 32'(cnt_limit), 0);
    reset = 1'b0;

    // 1: single job, limit 5.
    base = starts;
    set_limit(0, 5);
    push_job(0, 5);
    req = 4'b0001;
    wait_grant(20);
    req = '0;
    check_eq("t1_grant", 32'(grant), 32'b0001);
    check_eq("t1_cnt_limit", 32'(cnt_limit), 5);
    check_eq("t1_busy", 32'(busy), 1);
    wait_idle(50);
    check_eq("t1_starts", 32'(starts - base), 1);

    // 2: all request, limit 3, round-robin from pointer 0.
    apply_reset();
    for (int i = 0; i < NR; i++) set_limit(i, 3);
    push_job(0, 3); push_job(1, 3); push_job(2, 3); push_job(3, 3); push_job(0, 3);
    base = done_seen;
    req = 4'b1111;
    wait_dones(base + 5, 200);
    req = '0;
    wait_idle(50);

    // 3: zero limit skips the counter.
    apply_reset();
    base = starts;
    set_limit(2, 0);
    push_job(2, 0);
    req = 4'b0100;
    wait_grant(20);
    req = '0;
    check_eq("t3_grant", 32'(grant), 32'b0100);
    wait_idle(20);
    check_eq("t3_starts", 32'(starts - base), 0);

    // 4: req dropped and limit changed mid-job.
    apply_reset();
    set_limit(0, 6);
    push_job(0, 6);
    req = 4'b0001;
    n = 0;
    while (!res_valid && n < 30) begin tick(); n++; end
    check_eq("t4_in_run", 32'(res_valid), 1);
    req = '0;
    set_limit(0, 9);
    wait_idle(50);
    check_eq("t4_cnt_limit", 32'(cnt_limit), 6);

    // 5: reset during a long job; counter keeps running.
    apply_reset();
    res_en = 1'b0;
    set_limit(0, 100);
    req = 4'b0001;
    n = 0;
    while (!res_valid && n < 30) begin tick(); n++; end
    req = '0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check_eq("t5_rst_grant", 32'(grant), 0);
    check_eq("t5_rst_busy", 32'(busy), 0);
    check_eq("t5_rst_res_valid", 32'(res_valid), 0);
    check_eq("t5_rst_cnt_limit", 32'(cnt_limit), 0);
    tick();
    reset = 1'b0;
    res_en = 1'b1;
    check_eq("t5_counter_still_running", 32'(cnt_counting), 1);
    set_limit(1, 2);
    push_job(1, 2);
    req = 4'b0010;
    viol = 0;
    n = 0;
    while (cnt_counting && n < 200) begin
      if (grant != '0) viol++;
      tick();
      n++;
    end
    check_eq("t5_no_grant_while_counting", 32'(viol), 0);
    wait_grant(10);
    req = '0;
    check_eq("t5_grant", 32'(grant), 32'b0010);
    wait_idle(30);

    // 6: req=1010 held for three jobs.
    apply_reset();
    set_limit(1, 2);
    set_limit(3, 2);
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
    push_job(1, 2); push_job(1, 2); push_job(1, 2);
`else
    push_job(1, 2); push_job(3, 2); push_job(1, 2);
`endif
    base = done_seen;
    req = 4'b1010;
    wait_dones(base + 3, 100);
    req = '0;
    wait_idle(30);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
